// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Memory-access stage. Takes the decoder's data-access controls,
//            checks alignment, runs one valid/ready bus transaction with
//            byte-lane steering and a timeout, and returns load data
//            right-justified and zero/sign-extended. Stalls the core for the
//            duration of the access.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        addr_valid_i,
    input  logic        d_we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  mask_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_valid_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i
);

    // Counter is at least 8 bits and grows if the timeout needs more.
    localparam int unsigned c_CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [1:0]           off_q;
    logic [3:0]           mask_q;
    logic                 sext_q;
    logic                 done_q;
    logic                 misalign_q;
    logic                 bus_err_q;
    logic [31:0]          rdata_q;
    logic                 bus_valid_q;
    logic                 bus_we_q;
    logic [31:0]          bus_addr_q;
    logic [3:0]           bus_wstrb_q;
    logic [31:0]          bus_wdata_q;

    logic                 req_aligned;
    logic [31:0]          rdata_shift;
    logic [31:0]          load_data;
    logic                 timeout_hit;

    // Alignment check: only byte, half and word masks are legal.
    always_comb begin
        req_aligned = 1'b0;
        case (mask_i)
            4'b0001: req_aligned = 1'b1;
            4'b0011: req_aligned = ~addr_i[0];
            4'b1111: req_aligned = (addr_i[1:0] == 2'b00);
            default: req_aligned = 1'b0;
        endcase
    end

    // Right-justify the returned lane, then trim and extend to access width.
    always_comb begin
        rdata_shift = bus_rdata_i >> {off_q, 3'b000};
        load_data   = rdata_shift;
        case (mask_q)
            4'b0001: load_data = {{24{sext_q & rdata_shift[7]}},  rdata_shift[7:0]};
            4'b0011: load_data = {{16{sext_q & rdata_shift[15]}}, rdata_shift[15:0]};
            default: load_data = rdata_shift;
        endcase
    end

    // A zero timeout parameter disables the abort entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == c_TIMEOUT);

    // Access sequencer with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            off_q       <= 2'b00;
            mask_q      <= 4'b0000;
            sext_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            rdata_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wstrb_q <= 4'b0000;
            bus_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (addr_valid_i) begin
                        if (req_aligned) begin
                            state_q     <= S_BUS;
                            cnt_q       <= '0;
                            off_q       <= addr_i[1:0];
                            mask_q      <= mask_i;
                            sext_q      <= sext_i;
                            bus_valid_q <= 1'b1;
                            bus_we_q    <= d_we_i;
                            bus_addr_q  <= {addr_i[31:2], 2'b00};
                            bus_wstrb_q <= mask_i << addr_i[1:0];
                            bus_wdata_q <= wdata_i << {addr_i[1:0], 3'b000};
                        end else begin
                            // Illegal request completes immediately, bus untouched.
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                            rdata_q    <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ready_i) begin
                        // Ready takes priority over a coincident timeout.
                        state_q     <= S_DONE;
                        bus_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        rdata_q     <= bus_we_q ? '0 : load_data;
                    end else if (timeout_hit) begin
                        state_q     <= S_DONE;
                        bus_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        bus_err_q   <= 1'b1;
                        rdata_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Single-cycle completion; request is not re-sampled here.
                    state_q    <= S_IDLE;
                    done_q     <= 1'b0;
                    misalign_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o     = addr_valid_i & ~done_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign misalign_o  = misalign_q;
    assign bus_err_o   = bus_err_q;
    assign bus_valid_o = bus_valid_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wstrb_o = bus_wstrb_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed, table-driven bench for load_store_unit with
//            hand-written sequences for timeout and mid-access reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        addr_valid;
    logic        d_we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic        sext;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .addr_valid_i (addr_valid),
        .d_we_i       (d_we),
        .addr_i       (addr),
        .mask_i       (mask),
        .sext_i       (sext),
        .wdata_i      (wdata),
        .stall_o      (stall),
        .done_o       (done),
        .rdata_o      (rdata),
        .misalign_o   (misalign),
        .bus_err_o    (bus_err),
        .bus_valid_o  (bus_valid),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_wstrb_o  (bus_wstrb),
        .bus_wdata_o  (bus_wdata),
        .bus_ready_i  (bus_ready),
        .bus_rdata_i  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          waits;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge; ends just after a rising edge.
    task automatic do_access(input vec_t v, input string tag);
        addr_valid = 1'b1;
        d_we       = v.we;
        addr       = v.addr;
        mask       = v.mask;
        sext       = v.sext;
        wdata      = v.wdata;
        bus_ready  = 1'b0;
        @(negedge clk);
        check({tag, " stall_accept"}, stall, 1);
        check({tag, " valid_accept"}, bus_valid, 0);
        @(posedge clk); #1;
        if (v.exp_mis) begin
            @(negedge clk);
            check({tag, " mis_done"}, done, 1);
            check({tag, " mis_flag"}, misalign, 1);
            check({tag, " mis_nobus"}, bus_valid, 0);
            check({tag, " mis_err"}, bus_err, 0);
            check({tag, " mis_rdata"}, rdata, 0);
            check({tag, " mis_stall"}, stall, 0);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                if (w == v.waits) begin
                    bus_ready = 1'b1;
                    bus_rdata = v.brdata;
                end else begin
                    bus_rdata = 32'hBAD0_0BAD;
                end
                @(negedge clk);
                check({tag, " bus_valid"}, bus_valid, 1);
                check({tag, " bus_we"}, bus_we, v.we);
                check({tag, " bus_addr"}, bus_addr, v.exp_addr);
                check({tag, " bus_wstrb"}, bus_wstrb, v.exp_strb);
                check({tag, " bus_wdata"}, bus_wdata, v.exp_wdata);
                check({tag, " stall_bus"}, stall, 1);
                check({tag, " done_early"}, done, 0);
                @(posedge clk); #1;
            end
            bus_ready = 1'b0;
            @(negedge clk);
            check({tag, " done"}, done, 1);
            check({tag, " rdata"}, rdata, v.exp_rdata);
            check({tag, " misalign"}, misalign, 0);
            check({tag, " bus_err"}, bus_err, 0);
            check({tag, " valid_done"}, bus_valid, 0);
            check({tag, " stall_done"}, stall, 0);
        end
        @(posedge clk); #1;
        addr_valid = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, done, 0);
        check({tag, " rdata_hold"}, rdata, v.exp_mis ? 32'h0 : v.exp_rdata);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [3:0] m,
                                input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                                input int wt, input logic mis, input logic [31:0] ea,
                                input logic [3:0] es, input logic [31:0] ew, input logic [31:0] er);
        vec_t v;
        v.we = we; v.addr = a; v.mask = m; v.sext = sx; v.wdata = wd; v.brdata = rd;
        v.waits = wt; v.exp_mis = mis; v.exp_addr = ea; v.exp_strb = es;
        v.exp_wdata = ew; v.exp_rdata = er;
        return v;
    endfunction

    initial begin
        vec_t lw;
        //             we  addr          mask     sx  wdata         bus rdata     wt mis exp addr      strb     exp wdata     exp rdata
        vecs[0]  = mk(0, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF);
        vecs[1]  = mk(0, 32'h0000_0203, 4'b0001, 1, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'hFFFF_FF80);
        vecs[2]  = mk(0, 32'h0000_0203, 4'b0001, 0, 32'h0,        32'h80FF_1234, 1, 0, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_0080);
        vecs[3]  = mk(1, 32'h0000_0302, 4'b0011, 0, 32'h0000_ABCD, 32'h1234_5678, 3, 0, 32'h0000_0300, 4'b1100, 32'hABCD_0000, 32'h0);
        vecs[4]  = mk(0, 32'h0000_0101, 4'b1111, 0, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
        vecs[5]  = mk(0, 32'h0000_0102, 4'b0011, 1, 32'h0,        32'h8001_0000, 2, 0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF_8001);
        vecs[6]  = mk(0, 32'h0000_0000, 4'b0011, 0, 32'h0,        32'h1234_F00D, 0, 0, 32'h0000_0000, 4'b0011, 32'h0,        32'h0000_F00D);
        vecs[7]  = mk(1, 32'h0000_0001, 4'b0001, 0, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 4'b0010, 32'h0000_A500, 32'h0);
        vecs[8]  = mk(0, 32'h0000_0003, 4'b0011, 1, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
        vecs[9]  = mk(0, 32'h0000_0000, 4'b0111, 0, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0000, 32'h0,        32'h0);
        vecs[10] = mk(1, 32'hABCD_0008, 4'b1111, 0, 32'h1122_3344, 32'h0,         1, 0, 32'hABCD_0008, 4'b1111, 32'h1122_3344, 32'h0);
        vecs[11] = mk(0, 32'h0000_0002, 4'b0001, 1, 32'h0,        32'h007F_0000, 0, 0, 32'h0000_0000, 4'b0100, 32'h0,        32'h0000_007F);

        reset_n = 1'b0; addr_valid = 1'b0; d_we = 1'b0; addr = '0; mask = '0;
        sext = 1'b0; wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst done", done, 0);
        check("rst rdata", rdata, 0);
        check("rst misalign", misalign, 0);
        check("rst bus_err", bus_err, 0);
        check("rst bus_valid", bus_valid, 0);
        check("rst bus_we", bus_we, 0);
        check("rst bus_addr", bus_addr, 0);
        check("rst bus_wstrb", bus_wstrb, 0);
        check("rst bus_wdata", bus_wdata, 0);
        check("rst stall", stall, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i], $sformatf("v%0d", i));
        end

        // Timeout: ready never arrives, bus_valid for 5 cycles then error.
        addr_valid = 1'b1; d_we = 1'b0; addr = 32'h0000_0400; mask = 4'b1111; sext = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("to valid%0d", i), bus_valid, 1);
            check($sformatf("to nodone%0d", i), done, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to done", done, 1);
        check("to bus_err", bus_err, 1);
        check("to valid_low", bus_valid, 0);
        check("to rdata", rdata, 0);
        check("to misalign", misalign, 0);
        @(posedge clk); #1;
        addr_valid = 1'b0;
        @(negedge clk);
        check("to err_pulse", bus_err, 0);
        check("to done_pulse", done, 0);
        @(posedge clk); #1;

        // Ready on the final allowed cycle wins over timeout.
        addr_valid = 1'b1; addr = 32'h0000_0404;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus_ready = 1'b1;
                bus_rdata = 32'hCAFE_F00D;
            end
            @(negedge clk);
            check($sformatf("tr valid%0d", i), bus_valid, 1);
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        @(negedge clk);
        check("tr done", done, 1);
        check("tr bus_err", bus_err, 0);
        check("tr rdata", rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        addr_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during BUS aborts without a done pulse.
        addr_valid = 1'b1; addr = 32'h0000_0500;
        @(posedge clk); #1;
        @(negedge clk);
        check("rb valid_before", bus_valid, 1);
        reset_n = 1'b0;
        addr_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rb valid_after", bus_valid, 0);
        check("rb no_done", done, 0);
        check("rb rdata", rdata, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rb no_done2", done, 0);
        @(posedge clk); #1;

        lw = mk(0, 32'h0000_0600, 4'b1111, 0, 32'h0, 32'h0BAD_CAFE, 0, 0,
                32'h0000_0600, 4'b1111, 32'h0, 32'h0BAD_CAFE);
        do_access(lw, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage placed directly downstream of the instruction decoder. It consumes the decoder's data-access controls: address valid, write enable, effective address, byte mask and sign-extend flag, plus the rs2 store data. It performs the access on a valid/ready data bus, with byte-lane steering, alignment checking and a bus timeout. Load data is returned right-justified and zero- or sign-extended for register-file writeback, and the core is stalled for the duration of the access.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles to wait for `bus_ready_i` before aborting; 0 disables the timeout.
- clk  in  1  system clock; all state updates on rising edge
- reset_n_i  in  1  reset, synchronous, active-low
- addr_valid_i  in  1  decoder requests a data access
- d_we_i  in  1  1 = store, 0 = load
- addr_i  in  32  effective byte address
- mask_i  in  4  0001 byte, 0011 half, 1111 word (right-justified)
- sext_i  in  1  sign-extend load result
- wdata_i  in  32  store data, right-justified (rs2)
- stall_o  out  1  core must hold PC and decoder inputs
- done_o  out  1  one-cycle pulse: access finished (success or error)
- rdata_o  out  32  formatted load data, valid while done_o=1 for a successful load
- misalign_o  out  1  one-cycle pulse with done_o: misaligned request, no bus cycle
- bus_err_o  out  1  one-cycle pulse with done_o: timeout abort
- bus_valid_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word address ({addr_i[31:2],2'b00})
- bus_wstrb_o  out  4  byte strobes
- bus_wdata_o  out  32  lane-steered write data
- bus_ready_i  in  1  bus completes the request this cycle
- bus_rdata_i  in  32  read data, valid when bus_ready_i=1 on a read

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE: on addr_valid_i=1, check alignment.
  - Aligned: byte always; half requires addr_i[0]=0; word requires addr_i[1:0]=0. Register the bus outputs and move to BUS.
  - Misaligned, or any other mask value: move to DONE with the misalign flag set and no bus activity.
- Byte offset o = addr_i[1:0].
  - bus_wstrb_o = mask_i << o.
  - bus_wdata_o = wdata_i << 8*o.
  - On a read, bus_wstrb_o still carries the shifted mask.
- BUS:
  - bus_valid_o=1 and all bus outputs held constant until the cycle with bus_ready_i=1.
  - In that cycle, a load captures (bus_rdata_i >> 8*o) masked to the access width, extended per the latched sext, then moves to DONE.
  - Timeout counter (8+ bits, sized from TIMEOUT_CYCLES) is cleared on entry and increments each BUS cycle without ready. When it reaches TIMEOUT_CYCLES (if nonzero), drop bus_valid_o, set the error flag and move to DONE.
  - Ready in the same cycle as the timeout: ready wins, no error.
- DONE:
  - done_o=1 for exactly one cycle, with the error flags if set.
  - rdata_o holds the captured value; it is 0 after a store or error.
  - Always returns to IDLE. addr_valid_i is never re-sampled in DONE, so the same instruction is not repeated.
- stall_o = addr_valid_i & ~done_o (combinational). It is low whenever no access is requested.
- Stores: rdata_o = 0; the decoder leaves reg_in_en low.

## Timing
- Reset values (reset_n_i=0 at an edge):
  - State IDLE, counter 0, rdata_o=0.
  - bus_valid_o, bus_we_o, done_o, misalign_o, bus_err_o all 0.
  - bus_addr_o, bus_wstrb_o, bus_wdata_o all 0.
- Reset mid-access aborts immediately: bus_valid_o is 0 in the cycle after the reset edge and no done_o is produced.
- Bus outputs are registered.
  - Acceptance at cycle N gives bus_valid_o=1 at N+1.
  - Ready at cycle M gives done_o at M+1.
  - Minimum successful latency: done_o 2 cycles after acceptance. The core stalls 2 cycles and advances on the done_o cycle edge.
- Misaligned request: done_o/misalign_o 1 cycle after acceptance.
- Timeout: bus_err_o/done_o at N+1+TIMEOUT_CYCLES+1 with bus silent.
- Back-to-back accesses: the next request is accepted in the first IDLE cycle after DONE, so the minimum period is 3 cycles.
- rdata_o and error flags change only on the DONE entry edge.

## Test plan
- LW at 0x100, bus ready immediately with rdata 0xDEADBEEF -> bus_valid at N+1, wstrb 1111, done_o at N+2 with rdata_o=0xDEADBEEF; stall_o high at N and N+1.
- LB sext at 0x203, bus rdata 0x80FF1234 -> bus_addr 0x200, wstrb 1000, rdata_o=0xFFFFFF80. The same access with LBU -> 0x00000080.
- SH at 0x302, wdata 0x0000ABCD, ready after 3 wait cycles -> wstrb 1100, wdata 0xABCD0000, bus outputs stable through the waits, done_o one cycle after ready.
- LW at 0x101 -> no bus_valid, misalign_o and done_o pulse 1 cycle after acceptance.
- TIMEOUT_CYCLES=4, ready never asserted -> bus_valid high 5 cycles then low, bus_err_o and done_o pulse. Repeat with ready on the final cycle -> success, no error.
- reset_n_i low during BUS -> next cycle bus_valid_o=0, state IDLE, no done_o. A following aligned LW completes normally.
